// File: rtl/vga_pkg.sv
// Shared VGA definitions: raster constants, stream-word layout, pattern/state enums and the
// test-pattern colour function used by the pixel source.
package vga_pkg;

  localparam int unsigned HD = 640;
  localparam int unsigned VD = 480;
  localparam int unsigned HF = 16;
  localparam int unsigned HB = 48;
  localparam int unsigned HR = 96;
  localparam int unsigned VF = 10;
  localparam int unsigned VB = 33;
  localparam int unsigned VR = 2;

  localparam int unsigned CoordW   = 12;
  localparam int unsigned MaxCd    = 24;
  localparam int unsigned StartBit = 0;
  localparam int unsigned ColorLsb = 1;

  typedef enum logic [1:0] {
    PAT_SOLID = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  // x_hi is x[9:5], y5 is y[5]; result is packed {r,g,b} right-aligned in MaxCd bits.
  function automatic logic [MaxCd-1:0] pixel_color(input int unsigned   cd,
                                                   input logic [4:0]    x_hi,
                                                   input logic          y5,
                                                   input logic [2:0]    bar,
                                                   input pattern_e      pat,
                                                   input logic [MaxCd-1:0] fg);
    logic [MaxCd-1:0] ones, r, g, b, grey, color;
    int unsigned c;
    c     = cd / 3;
    ones  = MaxCd'((32'd1 << c) - 32'd1);
    grey  = MaxCd'(x_hi[4:1]) & ones;
    r     = bar[0] ? ones : '0;
    g     = bar[1] ? ones : '0;
    b     = bar[2] ? ones : '0;
    color = '0;
    unique case (pat)
      PAT_SOLID: color = fg;
      PAT_BARS:  color = (r << (2 * c)) | (g << c) | b;
      PAT_GRAD:  color = (grey << (2 * c)) | (grey << c) | grey;
      PAT_CHECK: color = (x_hi[0] ^ y5) ? fg : '0;
      default:   color = '0;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/vga_pattern_src_if.sv
// Pixel stream between the pattern source and the VGA sync core: {color, start} with valid/ready.
interface vga_pattern_src_if #(
  parameter int unsigned CD = 12
) ();
  import vga_pkg::*;

  logic [CD:0] vga_so_data;
  logic        vga_so_valid;
  logic        vga_so_ready;

  modport master (output vga_so_data, output vga_so_valid, input vga_so_ready);
  modport slave  (input vga_so_data, input vga_so_valid, output vga_so_ready);

endinterface

// File: rtl/vga_pattern_src.sv
// Test-pattern frame source: streams HD x VD pixels per frame from a registered output word,
// tagging pixel (0,0) with the start bit.
module vga_pattern_src
  import vga_pkg::*;
#(
  parameter int unsigned CD = 12,
  parameter int unsigned HD = vga_pkg::HD,
  parameter int unsigned VD = vga_pkg::VD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         pattern_sel,
  input  logic [CD-1:0]      fg_color,
  vga_pattern_src_if.master  so,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned BarW = HD / 8;

  state_e              state_q, state_d;
  logic [CoordW-1:0]   x_q, x_d, y_q, y_d, barpx_q, barpx_d;
  logic [2:0]          bar_q, bar_d;
  pattern_e            pat_q, pat_d;
  logic [CD-1:0]       fg_q, fg_d;
  logic [CD:0]         data_q, data_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [MaxCd-1:0]    color_full;

  logic accept, last_x, last_y, frame_end, load_first, advance;

  assign accept     = (state_q == StGen) && so.vga_so_ready;
  assign last_x     = (x_q == CoordW'(HD - 1));
  assign last_y     = (y_q == CoordW'(VD - 1));
  assign frame_end  = accept && last_x && last_y;
  // A new frame starts either from idle or back-to-back on the final accept.
  assign load_first = ((state_q == StIdle) || frame_end) && en;
  assign advance    = accept && !frame_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StGen;
      StGen:   if (frame_end && !en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    so.vga_so_valid = 1'b0;
    busy            = 1'b0;
    unique case (state_q)
      StGen: begin
        so.vga_so_valid = 1'b1;
        busy            = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    barpx_d     = barpx_q;
    bar_d       = bar_q;
    pat_d       = pat_q;
    fg_d        = fg_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;

    if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;

    if (load_first) begin
      x_d     = '0;
      y_d     = '0;
      barpx_d = '0;
      bar_d   = '0;
      pat_d   = pattern_e'(pattern_sel);
      fg_d    = fg_color;
    end else if (advance) begin
      if (last_x) begin
        x_d     = '0;
        y_d     = y_q + CoordW'(1);
        barpx_d = '0;
        bar_d   = '0;
      end else begin
        x_d = x_q + CoordW'(1);
        // Bar index is tracked incrementally so no divider is needed.
        if (barpx_q == CoordW'(BarW - 1)) begin
          barpx_d = '0;
          bar_d   = bar_q + 3'd1;
        end else begin
          barpx_d = barpx_q + CoordW'(1);
        end
      end
    end

    color_full = pixel_color(CD, x_d[9:5], y_d[5], bar_d, pat_d, MaxCd'(fg_d));
    if (load_first || advance) begin
      data_d = {color_full[CD-1:0], (x_d == '0) && (y_d == '0)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      barpx_q     <= '0;
      bar_q       <= '0;
      pat_q       <= PAT_SOLID;
      fg_q        <= '0;
      data_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      barpx_q     <= barpx_d;
      bar_q       <= bar_d;
      pat_q       <= pat_d;
      fg_q        <= fg_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign so.vga_so_data = data_q;
  assign frame_cnt      = frame_cnt_q;

endmodule
